// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types and default framing constants for the serial frame deserializer
// and the upstream delay-line bench.
package serial_frame_deserializer_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_SYNC_LEN = 4;
  localparam logic [DEFAULT_SYNC_LEN-1:0] DEFAULT_SYNC_PATTERN = 4'b1011;

endpackage

// File: rtl/serial_frame_deserializer_if.sv
// Serial-in / parallel-word-out bundle; master is the deserializer, slave the
// side that feeds bits and consumes words.
interface serial_frame_deserializer_if
  import serial_frame_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;

  modport master (
    input  din, dout_ready,
    output dout, dout_valid, busy, overrun
  );

  modport slave (
    output din, dout_ready,
    input  dout, dout_valid, busy, overrun
  );

endinterface

// File: rtl/serial_frame_deserializer_sync_detector.sv
// Sliding window over the serial stream; flags the edge at which the window
// (including the bit being sampled) equals the sync pattern.
module serial_frame_deserializer_sync_detector
  import serial_frame_deserializer_pkg::*;
#(
  parameter int unsigned                SYNC_LEN     = DEFAULT_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]        SYNC_PATTERN = DEFAULT_SYNC_PATTERN
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic match_c
);

  logic [SYNC_LEN-1:0] window_q;
  logic [SYNC_LEN-1:0] window_next_c;

  assign window_next_c = {window_q[SYNC_LEN-2:0], din};
  assign match_c       = en && (window_next_c == SYNC_PATTERN);

  // Clear wins over enable so a finished frame always restarts from an empty window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q <= '0;
    end else if (clr) begin
      window_q <= '0;
    end else if (en) begin
      window_q <= window_next_c;
    end
  end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Hunts for a sync pattern on the delayed serial bit, collects WIDTH data bits
// and hands the word out through a single-entry valid/ready slot.
module serial_frame_deserializer
  import serial_frame_deserializer_pkg::*;
#(
  parameter int unsigned         WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned         SYNC_LEN     = DEFAULT_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN,
  parameter bit                  MSB_FIRST    = 1'b1
) (
  input logic                          clk,
  input logic                          rst,
  serial_frame_deserializer_if.master  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               busy_q;

  logic               win_en_c;
  logic               win_clr_c;
  logic               match_c;
  logic               slot_free_c;
  logic [WIDTH-1:0]   word_c;

  serial_frame_deserializer_sync_detector #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .en      (win_en_c),
    .clr     (win_clr_c),
    .din     (bus.din),
    .match_c (match_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d == COLLECT);
    end
  end

  // Next state, shift path and output slot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    win_en_c    = 1'b0;
    win_clr_c   = 1'b0;
    slot_free_c = !valid_q || bus.dout_ready;

    if (MSB_FIRST) begin
      word_c = {shreg_q[WIDTH-2:0], bus.din};
    end else begin
      word_c = {bus.din, shreg_q[WIDTH-1:1]};
    end

    // An accept frees the slot; a same-edge completion below reloads it.
    if (valid_q && bus.dout_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      HUNT: begin
        win_en_c = 1'b1;
        if (match_c) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        shreg_d = word_c;
        if (cnt_q == LAST_CNT) begin
          state_d   = HUNT;
          cnt_d     = '0;
          win_clr_c = 1'b1;
          if (slot_free_c) begin
            dout_d  = word_c;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule
